// File: rtl/cpu_types_pkg.sv
// Shared types for the dcache/RAM bus: word, RAM handshake state and bus controller state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE,
        WB,
        SNOOP,
        C2C,
        RAMRD
    } bus_state_t;

endpackage

// File: rtl/bus_arb.sv
// Two-cache request arbiter. Macro BUS_CTRL_RR_EN: round-robin on ties (owns ptr),
// otherwise fixed priority with cache 0 winning ties.
module bus_arb (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       done_i,
    input  logic       done_id_i,
    output logic       gnt_o,
    output logic       valid_o
);

    assign valid_o = |req_i;

`ifdef BUS_CTRL_RR_EN
    logic ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (done_i) ptr_d = ~done_id_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ptr_q <= 1'b0;
        else       ptr_q <= ptr_d;
    end

    always_comb begin
        gnt_o = ~req_i[0];
        if (req_i == 2'b11) gnt_o = ptr_q;
    end
`else
    logic unused_arb;
    assign unused_arb = ^{clk_i, rst_i, done_i, done_id_i};

    assign gnt_o = ~req_i[0];
`endif

endmodule

// File: rtl/bus_ctrl.sv
// Memory-side responder for two dcaches: arbitration, snoop, RAM or cache-to-cache block service.
// Tie-break policy selected by macro BUS_CTRL_RR_EN (see bus_arb).
module bus_ctrl
    import cpu_types_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       dREN,
    input  logic [1:0]       dWEN,
    input  word_t [1:0]      daddr,
    input  word_t [1:0]      dstore,
    input  logic [1:0]       ccwrite,
    input  logic [1:0]       cctrans,
    output logic [1:0]       dwait,
    output word_t [1:0]      dload,
    output logic [1:0]       ccwait,
    output logic [1:0]       ccinv,
    output word_t [1:0]      ccsnoopaddr,
    output logic             ramREN,
    output logic             ramWEN,
    output word_t            ramaddr,
    output word_t            ramstore,
    input  word_t            ramload,
    input  ramstate_t        ramstate
);

    bus_state_t state_q, state_d;
    logic       g_q, g_d;
    logic       wc_q, wc_d;
    logic       inv_q, inv_d;
    logic       o;
    logic       xfer;
    logic       done;
    logic       arb_gnt, arb_valid;

    assign o = ~g_q;

    bus_arb u_arb (
        .clk_i     (CLK),
        .rst_i     (RST),
        .req_i     (dREN | dWEN),
        .done_i    (done),
        .done_id_i (g_q),
        .gnt_o     (arb_gnt),
        .valid_o   (arb_valid)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            g_q     <= 1'b0;
            wc_q    <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            wc_q    <= wc_d;
            inv_q   <= inv_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        wc_d        = wc_q;
        inv_d       = inv_q;
        xfer        = 1'b0;
        done        = 1'b0;
        dwait       = 2'b11;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;

        case (state_q)
            IDLE: begin
                wc_d = 1'b0;
                if (arb_valid) begin
                    g_d     = arb_gnt;
                    inv_d   = ccwrite[arb_gnt];
                    state_d = dWEN[arb_gnt] ? WB : SNOOP;
                end
            end
            WB: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr[g_q];
                ramstore = dstore[g_q];
                xfer     = 1'b1;
            end
            SNOOP: begin
                ccwait[o]      = 1'b1;
                ccsnoopaddr[o] = daddr[g_q];
                ccinv[o]       = inv_q;
                if (cctrans[o]) state_d = ccwrite[o] ? C2C : RAMRD;
            end
            C2C: begin
                // Forwarded word is also written back so RAM stays coherent.
                ccwait[o]      = 1'b1;
                ccsnoopaddr[o] = daddr[g_q];
                ramWEN         = 1'b1;
                ramaddr        = daddr[g_q];
                ramstore       = dstore[o];
                dload[g_q]     = dstore[o];
                xfer           = 1'b1;
            end
            RAMRD: begin
                ramREN     = 1'b1;
                ramaddr    = daddr[g_q];
                dload[g_q] = ramload;
                xfer       = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (xfer && ramstate == ACCESS) begin
            dwait[g_q] = 1'b0;
            wc_d       = ~wc_q;
            if (wc_q) begin
                state_d = IDLE;
                done    = 1'b1;
            end
        end
    end

endmodule

// File: doc/bus_ctrl.md
# bus_ctrl

Memory-side responder for the two data caches' miss/writeback and snoop protocol: arbitrates `dREN`/`dWEN` requests from cache 0 and cache 1, snoops the non-requesting cache, and services each two-word block from RAM or by cache-to-cache transfer. It sits between the per-core dcache control FSMs and the single-ported RAM. It generates the `dwait`/`dload`/`ccwait`/`ccinv`/`ccsnoopaddr` signals those FSMs consume.

## Interface
- No parameters; fixed at 2 caches, 2-word blocks (`word_t` = 32 bits).
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-high
- dREN  in  [1:0]  per-cache block read request (miss)
- dWEN  in  [1:0]  per-cache block write request (eviction/flush writeback)
- daddr  in  word_t[1:0]  per-cache word address; bit 2 selects word within block
- dstore  in  word_t[1:0]  per-cache write data; also snoop-supply data
- ccwrite  in  [1:0]  requester: read-exclusive intent; snooped cache: holds modified copy
- cctrans  in  [1:0]  snooped cache's response-valid strobe
- dwait  out  [1:0]  low for exactly the cycle a word completes for that cache
- dload  out  word_t[1:0]  read data to each cache
- ccwait  out  [1:0]  snoop in progress on that cache
- ccinv  out  [1:0]  snooped cache must invalidate
- ccsnoopaddr  out  word_t[1:0]  address presented to snooped cache
- ramREN, ramWEN  out  1  RAM strobes
- ramaddr, ramstore  out  word_t  RAM address/data
- ramload  in  word_t  RAM read data
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR

## Operation
- States: IDLE, WB, SNOOP, C2C, RAMRD. Registers: state, grant id g (1 bit), word count wc (1 bit), priority ptr.
- IDLE: any request pending → grant one; dWEN → WB, dREN → SNOOP; wc←0. Both caches requesting → cache = ptr wins. dWEN and dREN from same cache: dWEN wins.
- WB: ramWEN=1, ramaddr=daddr[g], ramstore=dstore[g]. On ramstate==ACCESS: dwait[g]=0, wc toggles. Second ACCESS → IDLE. No snoop.
- SNOOP: o = ~g; ccwait[o]=1, ccsnoopaddr[o]=daddr[g], ccinv[o]=ccwrite[g] (ccwrite[g] latched at grant). Waits for cctrans[o]: ccwrite[o]=1 → C2C, else → RAMRD.
- C2C: ccwait[o]=1, ccsnoopaddr[o]=daddr[g]; ramWEN=1, ramaddr=daddr[g], ramstore=dstore[o]; dload[g]=dstore[o]. On ACCESS: dwait[g]=0, wc toggles. Second ACCESS → IDLE. RAM copy is thereby updated.
- RAMRD: ramREN=1, ramaddr=daddr[g], dload[g]=ramload. On ACCESS: dwait[g]=0. Second ACCESS → IDLE.
- Exit to IDLE flips ptr to ~g.
- BUSY/ERROR/FREE: hold state and strobes, dwait stays high (retry).
- Requests are sampled only in IDLE. A deassertion mid-transaction is ignored; the two-word transaction completes.
- Non-granted cache: dwait=1, ccwait=0 unless it is o in SNOOP/C2C.
- Word order is driven by the requester's daddr; the controller only counts completions.

## Timing
- Reset values: state=IDLE, ptr=0, wc=0, dwait=2'b11, ccwait=0, ccinv=0, ccsnoopaddr=0, dload=0, ramREN=ramWEN=0, ramaddr=ramstore=0.
- All outputs are Moore from state, except that dwait/dload/ramstore/ramaddr follow ramstate, ramload, dstore and daddr combinationally in the same cycle.
- A request seen in IDLE at edge N produces ccwait (read) or ramWEN (writeback) in cycle N+1.
- The SNOOP→C2C/RAMRD decision is made on the edge where cctrans[o]=1, so there is at least 1 snoop cycle.
- Minimum read latency with 0-wait RAM: 1 (IDLE) + 1 (SNOOP) + 2 words = 4 cycles.
- Back-to-back: the next grant is taken in IDLE, so there is a minimum 1 IDLE cycle between transactions.
- RST mid-transaction: immediate return to reset values; any partial block is abandoned.

## Configuration
- BUS_CTRL_RR_EN defined: round-robin arbitration; ptr flips on every completion, as above.
- Undefined: fixed priority, cache 0 always wins ties; ptr register is removed.

## Structure
- Shared package cpu_types_pkg: word_t, ramstate_t, and a new bus_state_t enum {IDLE, WB, SNOOP, C2C, RAMRD}.
- One natural sub-module: bus_arb, which takes the 2 request bits plus ptr and produces the grant and valid. It owns ptr under BUS_CTRL_RR_EN.

## Test plan
- Cache 0 dREN, daddr=0x100/0x104, cache 1 replies cctrans=1, ccwrite=0, RAM ACCESS every cycle → ccwait[1] for 1 cycle, dload[0]=ramload, dwait[0] low 2 cycles, back to IDLE in 4 cycles.
- Cache 1 dREN with ccwrite=1, cache 0 replies ccwrite=1, dstore[0]=0xDEAD_BEEF then 0xCAFE_F00D → ccinv[0]=1, ramWEN with ramstore equal to those words, dload[1] forwards them.
- Cache 0 dWEN, words 0xAAAA_0000/0xAAAA_0004, ramstate BUSY 3 cycles then ACCESS → dwait[0] stays high during BUSY, ramWEN held, exactly 2 completions, no ccwait.
- Both caches dREN at the same edge from reset → cache 0 served first, then cache 1. Repeat with RR: next tie goes to cache 1; without BUS_CTRL_RR_EN it goes to cache 0.
- Assert RST during C2C after word 0 → all outputs at reset values the same cycle, state IDLE, new request accepted normally.
- ramstate=ERROR for 2 cycles during RAMRD → no dwait drop, ramREN held, completes after subsequent ACCESS.
